// File: rtl/iterative_shifter_if.sv
// Request/response bundle between the control unit and the iterative shifter.
// Define SHIFTER_CARRY_OUT_EN to add the carry_out signal.
interface iterative_shifter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [1:0]       shift_op;
  logic [7:0]       shift_amt;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef SHIFTER_CARRY_OUT_EN
  logic             carry_out;
`endif

`ifdef SHIFTER_CARRY_OUT_EN
  modport master (output start, shift_op, shift_amt, data_in,
                  input  busy, done, result, carry_out);
  modport slave  (input  start, shift_op, shift_amt, data_in,
                  output busy, done, result, carry_out);
`else
  modport master (output start, shift_op, shift_amt, data_in,
                  input  busy, done, result);
  modport slave  (input  start, shift_op, shift_amt, data_in,
                  output busy, done, result);
`endif
endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle LSL/LSR/ASR/ROR engine, one bit position per clock.
// Optional feature macro: SHIFTER_CARRY_OUT_EN (adds carry_out).
module iterative_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  iterative_shifter_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sign_q, sign_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    amt_cnt;
`ifdef SHIFTER_CARRY_OUT_EN
  logic             carry_q, carry_d;
`endif

  // Effective count: saturate at WIDTH for shifts, wrap modulo WIDTH for rotate.
  always_comb begin
    if (op_e'(bus.shift_op) == OP_ROR) begin
      amt_cnt = CW'(32'(bus.shift_amt) % WIDTH);
    end else if (32'(bus.shift_amt) >= WIDTH) begin
      amt_cnt = CW'(WIDTH);
    end else begin
      amt_cnt = CW'(bus.shift_amt);
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    result_d = result_q;
    sign_d   = sign_q;
`ifdef SHIFTER_CARRY_OUT_EN
    carry_d  = carry_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          result_d = bus.data_in;
          op_d     = op_e'(bus.shift_op);
          sign_d   = bus.data_in[WIDTH-1];
          count_d  = amt_cnt;
`ifdef SHIFTER_CARRY_OUT_EN
          carry_d  = 1'b0;
`endif
          state_d  = (amt_cnt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        count_d = count_q - CW'(1);
        case (op_q)
          OP_LSL:  result_d = {result_q[WIDTH-2:0], 1'b0};
          OP_LSR:  result_d = {1'b0, result_q[WIDTH-1:1]};
          OP_ASR:  result_d = {sign_q, result_q[WIDTH-1:1]};
          default: result_d = {result_q[0], result_q[WIDTH-1:1]};
        endcase
`ifdef SHIFTER_CARRY_OUT_EN
        carry_d = (op_q == OP_LSL) ? result_q[WIDTH-1] : result_q[0];
`endif
        if (count_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= OP_LSL;
      count_q  <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SHIFTER_CARRY_OUT_EN
      carry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SHIFTER_CARRY_OUT_EN
      carry_q  <= carry_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
`ifdef SHIFTER_CARRY_OUT_EN
  assign bus.carry_out = carry_q;
`endif

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: directed corner cases plus random runs
// against an arithmetic reference model.
module tb_iterative_shifter;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  iterative_shifter_if #(.WIDTH(W)) bus_if ();

  iterative_shifter #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_n(input logic [1:0] op, input logic [7:0] amt);
    if (op == 2'b11) return int'(amt) % W;
    return (int'(amt) > W) ? W : int'(amt);
  endfunction

  function automatic logic [W-1:0] model_res(input logic [1:0] op, input int n,
                                             input logic [W-1:0] d);
    logic signed [W-1:0] s;
    logic [2*W-1:0]      dd;
    s  = d;
    dd = {d, d};
    case (op)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   return W'(s >>> n);
      default: return W'(dd >> n);
    endcase
  endfunction

  // Last bit to leave the operand.
  function automatic logic model_carry(input logic [1:0] op, input int n,
                                       input logic [W-1:0] d);
    logic [W-1:0] t;
    if (n == 0) return 1'b0;
    t = (op == 2'b00) ? (d >> (W - n)) : (d >> (n - 1));
    return t[0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE, check latency/result, then step into the following IDLE cycle.
  task automatic run_op(input logic [1:0] op, input logic [7:0] amt,
                        input logic [W-1:0] data, input string tag);
    int n;
    int cyc;
    logic [W-1:0] exp_r;
    n     = model_n(op, amt);
    exp_r = model_res(op, n, data);
    bus_if.start     = 1'b1;
    bus_if.shift_op  = op;
    bus_if.shift_amt = amt;
    bus_if.data_in   = data;
    step();
    bus_if.start     = 1'b0;
    bus_if.shift_op  = 2'($urandom);
    bus_if.shift_amt = 8'($urandom);
    bus_if.data_in   = W'($urandom);
    check_eq({tag, "_busy"}, 32'(bus_if.busy), 32'(1));
    cyc = 1;
    while (!bus_if.done && cyc <= int'(W) + 2) begin
      step();
      cyc++;
    end
    check_eq({tag, "_lat"}, 32'(cyc), 32'(n + 1));
    check_eq({tag, "_res"}, 32'(bus_if.result), 32'(exp_r));
`ifdef SHIFTER_CARRY_OUT_EN
    check_eq({tag, "_cy"}, 32'(bus_if.carry_out), 32'(model_carry(op, n, data)));
`endif
    step();
    check_eq({tag, "_idle"}, {30'd0, bus_if.busy, bus_if.done}, 32'(0));
    check_eq({tag, "_hold"}, 32'(bus_if.result), 32'(exp_r));
  endtask

  initial begin
    int dones;
    int cyc;
    checks = 0;
    errors = 0;
    rst_n            = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.shift_op  = 2'b00;
    bus_if.shift_amt = 8'd0;
    bus_if.data_in   = '0;
    step();
    step();
    check_eq("rst_busy", 32'(bus_if.busy), 32'(0));
    check_eq("rst_done", 32'(bus_if.done), 32'(0));
    check_eq("rst_res", 32'(bus_if.result), 32'(0));
    rst_n = 1'b1;
    step();

    // Reset in the middle of an ASR by 6: operation abandoned, no DONE afterwards.
    bus_if.start     = 1'b1;
    bus_if.shift_op  = 2'b10;
    bus_if.shift_amt = 8'd6;
    bus_if.data_in   = 8'h96;
    step();
    bus_if.start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    step();
    check_eq("midrst_busy", 32'(bus_if.busy), 32'(0));
    check_eq("midrst_done", 32'(bus_if.done), 32'(0));
    check_eq("midrst_res", 32'(bus_if.result), 32'(0));
`ifdef SHIFTER_CARRY_OUT_EN
    check_eq("midrst_cy", 32'(bus_if.carry_out), 32'(0));
`endif
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_if.done) dones++;
    end
    check_eq("midrst_nodone", 32'(dones), 32'(0));

    // Directed cases; each run_op ends on the first IDLE cycle, so they chain back-to-back.
    run_op(2'b00, 8'd3,   8'b1001_0110, "lsl3");
    check_eq("lsl3_val", 32'(bus_if.result), 32'(8'b1011_0000));
    run_op(2'b10, 8'd2,   8'b1000_0100, "asr2");
    check_eq("asr2_val", 32'(bus_if.result), 32'(8'b1110_0001));
    run_op(2'b10, 8'd200, 8'b1000_0100, "asr200");
    check_eq("asr200_val", 32'(bus_if.result), 32'(8'hFF));
    run_op(2'b11, 8'd9,   8'h81, "ror9");
    check_eq("ror9_val", 32'(bus_if.result), 32'(8'hC0));
    run_op(2'b01, 8'd0,   8'hA5, "lsr0");
    check_eq("lsr0_val", 32'(bus_if.result), 32'(8'hA5));
    run_op(2'b01, 8'd8,   8'hFF, "lsr8");
    check_eq("lsr8_val", 32'(bus_if.result), 32'(8'h00));
    run_op(2'b00, 8'd8,   8'hFF, "lsl8");
    run_op(2'b11, 8'd0,   8'h3C, "ror0");

    // START while busy must be ignored.
    bus_if.start     = 1'b1;
    bus_if.shift_op  = 2'b00;
    bus_if.shift_amt = 8'd5;
    bus_if.data_in   = 8'h5A;
    step();
    bus_if.start = 1'b0;
    step();
    bus_if.start     = 1'b1;
    bus_if.shift_op  = 2'b11;
    bus_if.shift_amt = 8'd1;
    bus_if.data_in   = 8'h00;
    step();
    bus_if.start = 1'b0;
    cyc = 3;
    while (!bus_if.done && cyc <= int'(W) + 2) begin
      step();
      cyc++;
    end
    check_eq("busy_start_lat", 32'(cyc), 32'(6));
    check_eq("busy_start_res", 32'(bus_if.result), 32'(8'h40));
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_if.done) dones++;
    end
    check_eq("busy_start_noq", 32'(dones), 32'(0));

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] amt;
      amt = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, W + 2)) : 8'($urandom);
      run_op(2'($urandom), amt, W'($urandom), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
